// File: rtl/fnd_display_scheduler.sv
// Selects which time source feeds the shared FND display, sequences the
// temporary PEEK / LAP hold modes, and produces blink masks for watch editing.
module fnd_display_scheduler #(
    parameter int unsigned CLK_DIV  = 100_000,
    parameter int unsigned HOLD_MS  = 2000,
    parameter int unsigned BLINK_MS = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_mode,
    input  logic        i_page,
    input  logic [23:0] i_watch_time,
    input  logic [23:0] i_sw_time,
    input  logic        i_sw_event,
    input  logic        i_lap,
    input  logic        i_edit_en,
    input  logic [1:0]  i_edit_field,
    output logic [23:0] o_time,
    output logic        o_page,
    output logic        o_src,
    output logic [3:0]  o_blank,
    output logic [1:0]  o_state
);

    localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HW = $clog2(HOLD_MS + 1);
    localparam int unsigned BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    localparam logic [1:0] ST_WATCH = 2'd0;
    localparam logic [1:0] ST_SW    = 2'd1;
    localparam logic [1:0] ST_PEEK  = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [HW-1:0] hold;
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          hold_load;
    logic          lap_load;
    logic [23:0]   lap_reg;
    logic [23:0]   lap_next;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_next;
    logic          phase;
    logic          phase_next;
    logic [1:0]    field_q;
    logic          field_changed;
    logic          blink_active;
    logic [3:0]    field_mask;

    assign tick = (tick_cnt == TW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Mode changes are checked first so they override event/lap pulses.
    always_comb begin
        state_next = state;
        hold_load  = 1'b0;
        lap_load   = 1'b0;
        case (state)
            ST_WATCH: begin
                if (i_mode) begin
                    state_next = ST_SW;
                end else if (i_sw_event) begin
                    state_next = ST_PEEK;
                    hold_load  = 1'b1;
                end
            end
            ST_SW: begin
                if (!i_mode) begin
                    state_next = ST_WATCH;
                end else if (i_lap) begin
                    state_next = ST_LAP;
                    lap_load   = 1'b1;
                    hold_load  = 1'b1;
                end
            end
            ST_PEEK: begin
                if (i_mode) begin
                    state_next = ST_SW;
                end else if (i_sw_event) begin
                    hold_load = 1'b1;
                end else if (tick && hold == HW'(1)) begin
                    state_next = ST_WATCH;
                end
            end
            ST_LAP: begin
                if (!i_mode) begin
                    state_next = ST_WATCH;
                end else if (i_lap) begin
                    lap_load  = 1'b1;
                    hold_load = 1'b1;
                end else if (tick && hold == HW'(1)) begin
                    state_next = ST_SW;
                end
            end
            default: state_next = ST_WATCH;
        endcase
    end

    assign lap_next = lap_load ? i_sw_time : lap_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else if (hold_load) begin
            hold <= HW'(HOLD_MS);
        end else if (tick && hold != '0) begin
            hold <= hold - HW'(1);
        end
    end

    assign blink_active  = (state_next == ST_WATCH) && i_edit_en;
    assign field_changed = (i_edit_field != field_q);

    always_comb begin
        blink_cnt_next = blink_cnt;
        phase_next     = phase;
        if (!blink_active || field_changed) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_MS - 1)) begin
                blink_cnt_next = '0;
                phase_next     = ~phase;
            end else begin
                blink_cnt_next = blink_cnt + BW'(1);
            end
        end
    end

    // Page 0 shows sec/msec (sec on the left pair); page 1 shows hour/min.
    always_comb begin
        field_mask = '0;
        case ({i_page, i_edit_field})
            3'b0_00: field_mask = 4'b1100;
            3'b1_01: field_mask = 4'b0011;
            3'b1_10: field_mask = 4'b1100;
            default: field_mask = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_WATCH;
            lap_reg   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            field_q   <= '0;
            o_time    <= '0;
            o_page    <= 1'b0;
            o_src     <= 1'b0;
            o_blank   <= '0;
        end else begin
            state     <= state_next;
            lap_reg   <= lap_next;
            blink_cnt <= blink_cnt_next;
            phase     <= phase_next;
            field_q   <= i_edit_field;
            o_src     <= (state_next != ST_WATCH);
            o_page    <= (state_next == ST_PEEK) ? 1'b0 : i_page;
            o_blank   <= (blink_active && phase_next) ? field_mask : '0;
            case (state_next)
                ST_WATCH: o_time <= i_watch_time;
                ST_LAP:   o_time <= lap_next;
                default:  o_time <= i_sw_time;
            endcase
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Directed and randomized checks of fnd_display_scheduler against a
// cycle-level behavioural model.
module tb_fnd_display_scheduler;

    localparam int CLK_DIV  = 4;
    localparam int HOLD_MS  = 3;
    localparam int BLINK_MS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_mode;
    logic        i_page;
    logic [23:0] i_watch_time;
    logic [23:0] i_sw_time;
    logic        i_sw_event;
    logic        i_lap;
    logic        i_edit_en;
    logic [1:0]  i_edit_field;
    logic [23:0] o_time;
    logic        o_page;
    logic        o_src;
    logic [3:0]  o_blank;
    logic [1:0]  o_state;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_state;
    int          m_hold;
    int          m_n;
    int          m_bcnt;
    int          m_field_prev;
    bit          m_phase;
    bit          m_tick;
    logic [23:0] m_lap;
    logic [23:0] e_time;
    logic        e_page;
    logic        e_src;
    logic [3:0]  e_blank;

    fnd_display_scheduler #(
        .CLK_DIV (CLK_DIV),
        .HOLD_MS (HOLD_MS),
        .BLINK_MS(BLINK_MS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_mode      (i_mode),
        .i_page      (i_page),
        .i_watch_time(i_watch_time),
        .i_sw_time   (i_sw_time),
        .i_sw_event  (i_sw_event),
        .i_lap       (i_lap),
        .i_edit_en   (i_edit_en),
        .i_edit_field(i_edit_field),
        .o_time      (o_time),
        .o_page      (o_page),
        .o_src       (o_src),
        .o_blank     (o_blank),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // State 0/2 belong to the watch side, 1/3 to the stopwatch side.
    task automatic model_step();
        int  ns;
        bit  reload;
        bit  act;
        logic [3:0] mask;
        if (reset) begin
            m_state = 0; m_hold = 0; m_n = 0; m_bcnt = 0; m_phase = 0;
            m_field_prev = 0; m_tick = 0; m_lap = '0;
            e_time = '0; e_page = 0; e_src = 0; e_blank = '0;
            return;
        end
        m_n++;
        m_tick = ((m_n % CLK_DIV) == 0);
        ns = m_state;
        reload = 0;
        if ((m_state == 0 || m_state == 2) && i_mode) ns = 1;
        else if ((m_state == 1 || m_state == 3) && !i_mode) ns = 0;
        else if ((m_state == 0 || m_state == 2) && i_sw_event) begin ns = 2; reload = 1; end
        else if ((m_state == 1 || m_state == 3) && i_lap) begin ns = 3; reload = 1; m_lap = i_sw_time; end
        else if (m_state >= 2 && m_tick && m_hold == 1) ns = m_state - 2;
        if (reload) m_hold = HOLD_MS;
        else if (m_tick && m_hold > 0) m_hold--;
        m_state = ns;

        e_time = (ns == 0) ? i_watch_time : (ns == 3) ? m_lap : i_sw_time;
        e_page = (ns == 2) ? 1'b0 : i_page;
        e_src  = (ns != 0);

        act = (ns == 0) && i_edit_en;
        if (!act || int'(i_edit_field) != m_field_prev) begin
            m_bcnt = 0;
            m_phase = 0;
        end else if (m_tick) begin
            m_bcnt++;
            if (m_bcnt == BLINK_MS) begin
                m_bcnt = 0;
                m_phase = !m_phase;
            end
        end
        m_field_prev = int'(i_edit_field);
        if (!i_page) mask = (i_edit_field == 2'd0) ? 4'b1100 : 4'b0000;
        else if (i_edit_field == 2'd1) mask = 4'b0011;
        else if (i_edit_field == 2'd2) mask = 4'b1100;
        else mask = 4'b0000;
        e_blank = (act && m_phase) ? mask : 4'b0000;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_eq("time",  32'(o_time),  32'(e_time));
        check_eq("page",  32'(o_page),  32'(e_page));
        check_eq("src",   32'(o_src),   32'(e_src));
        check_eq("blank", 32'(o_blank), 32'(e_blank));
        check_eq("state", 32'(o_state), 32'(m_state));
    endtask

    // Step until o_state leaves s; report how many ticks were seen on the way.
    task automatic run_until_leave(input logic [1:0] s, input bit inc_sw, output int ticks);
        ticks = 0;
        for (int k = 0; k < 100; k++) begin
            if (inc_sw) i_sw_time = i_sw_time + 24'd1;
            step();
            if (m_tick) ticks++;
            if (o_state != s) break;
        end
        check_eq("leave_timeout", 32'(o_state != s), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int cnt;
        bit saw_c;
        bit saw_0;
        logic [23:0] wt;

        reset = 1; i_mode = 0; i_page = 0; i_watch_time = 24'h0A_BCDE;
        i_sw_time = 24'h000123; i_sw_event = 0; i_lap = 0;
        i_edit_en = 0; i_edit_field = 2'd0;

        // reset
        repeat (3) step();
        check_eq("rst_time_zero", 32'(o_time), 32'h0);
        reset = 0;
        step();
        check_eq("rst_first_time", 32'(o_time), 32'h0A_BCDE);

        // mode switch
        i_mode = 1; i_page = 1;
        step();
        check_eq("sw_state", 32'(o_state), 32'd1);
        check_eq("sw_time", 32'(o_time), 32'h000123);
        i_mode = 0;
        step();
        check_eq("back_watch", 32'(o_state), 32'd0);

        // peek
        i_sw_event = 1;
        step();
        i_sw_event = 0;
        check_eq("peek_state", 32'(o_state), 32'd2);
        check_eq("peek_page", 32'(o_page), 32'd0);
        run_until_leave(2'd2, 1'b1, t);
        check_eq("peek_ticks", 32'(t), 32'd3);

        // peek extension
        i_sw_event = 1;
        step();
        i_sw_event = 0;
        cnt = 0;
        for (int k = 0; k < 40 && cnt < 2; k++) begin
            step();
            if (m_tick) cnt++;
        end
        check_eq("peek_2ticks_state", 32'(o_state), 32'd2);
        i_sw_event = 1;
        step();
        i_sw_event = 0;
        run_until_leave(2'd2, 1'b0, t);
        check_eq("peek_ext_ticks", 32'(t), 32'd3);

        // lap freeze
        i_mode = 1;
        step();
        i_sw_time = 24'h0010_32;
        i_lap = 1;
        step();
        i_lap = 0;
        check_eq("lap_state", 32'(o_state), 32'd3);
        check_eq("lap_time", 32'(o_time), 32'h0010_32);
        run_until_leave(2'd3, 1'b1, t);
        check_eq("lap_ticks", 32'(t), 32'd3);
        check_eq("lap_exit_state", 32'(o_state), 32'd1);
        check_eq("lap_resume", 32'(o_time), 32'(i_sw_time));
        i_lap = 1;
        step();
        i_lap = 0;
        step();
        i_mode = 0;
        step();
        check_eq("lap_mode_exit", 32'(o_state), 32'd0);

        // blink
        i_page = 1; i_edit_en = 1; i_edit_field = 2'd2;
        saw_c = 0; saw_0 = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (o_blank == 4'b1100) saw_c = 1;
            if (o_blank == 4'b0000) saw_0 = 1;
        end
        check_eq("blink_hour_on", 32'(saw_c), 32'd1);
        check_eq("blink_hour_off", 32'(saw_0), 32'd1);
        i_edit_field = 2'd1;
        step();
        check_eq("blink_fld_clr", 32'(o_blank), 32'h0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (m_tick) cnt++;
            if (o_blank != 4'b0000) break;
        end
        check_eq("blink_min_mask", 32'(o_blank), 32'h3);
        check_eq("blink_min_ticks", 32'(cnt), 32'd2);
        i_edit_field = 2'd0;
        for (int k = 0; k < 16; k++) begin
            step();
            check_eq("blink_sec_p1", 32'(o_blank), 32'h0);
        end
        i_edit_en = 0;

        // priority and reset mid-LAP
        i_mode = 1; i_sw_event = 1;
        step();
        i_sw_event = 0;
        check_eq("prio_state", 32'(o_state), 32'd1);
        i_lap = 1;
        step();
        i_lap = 0;
        step();
        check_eq("prio_lap", 32'(o_state), 32'd3);
        reset = 1;
        step();
        check_eq("rst_lap_state", 32'(o_state), 32'd0);
        check_eq("rst_lap_time", 32'(o_time), 32'h0);
        reset = 0; i_mode = 0;
        wt = 24'($urandom());
        i_watch_time = wt;
        step();
        check_eq("rst_lap_watch", 32'(o_time), 32'(wt));

        // randomized
        for (int k = 0; k < 3000; k++) begin
            reset        = ($urandom_range(499) == 0);
            if ($urandom_range(39) == 0) i_mode = ~i_mode;
            if ($urandom_range(19) == 0) i_page = ~i_page;
            if ($urandom_range(49) == 0) i_edit_en = ~i_edit_en;
            if ($urandom_range(29) == 0) i_edit_field = 2'($urandom_range(3));
            i_sw_event   = ($urandom_range(14) == 0);
            i_lap        = ($urandom_range(14) == 0);
            i_watch_time = 24'($urandom());
            i_sw_time    = 24'($urandom());
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fnd_display_scheduler.md
Name: fnd_display_scheduler

Overview:
- Owns the shared 4-digit FND display and decides which time source feeds the fnd_controller: the watch or the stopwatch.
- Sequences temporary display modes: a stopwatch "peek" while the watch is shown, and a frozen lap hold while the stopwatch is shown.
- Generates per-digit blink masks for watch time-setting.
- Sits between the watch/stopwatch datapaths and fnd_controller. It drives that block's i_time and sw0 inputs.

Parameters:
CLK_DIV, 100_000, clk cycles per internal 1 ms tick (100 MHz clk)
HOLD_MS, 2000, duration of PEEK and LAP hold, in ms ticks
BLINK_MS, 500, blink half-period, in ms ticks

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
i_mode  input  1  requested source: 0 = watch, 1 = stopwatch
i_page  input  1  requested page: 0 = msec/sec, 1 = min/hour
i_watch_time  input  24  watch time, packed {hour[23:19], min[18:13], sec[12:7], msec[6:0]}
i_sw_time  input  24  stopwatch time, same packing
i_sw_event  input  1  one-clk pulse: stopwatch start/stop/clear occurred
i_lap  input  1  one-clk pulse: lap request
i_edit_en  input  1  watch time-setting active
i_edit_field  input  2  0 = sec, 1 = min, 2 = hour, 3 = reserved
o_time  output  24  time to display; drives fnd_controller i_time
o_page  output  1  page select; drives fnd_controller sw0
o_src  output  1  0 = watch shown, 1 = stopwatch shown (PEEK and LAP included)
o_blank  output  4  per-digit blank request; bit0 = rightmost digit (fnd_com bit0)
o_state  output  2  current state: WATCH=0, SW=1, PEEK=2, LAP=3

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state WATCH, o_time=0, o_page=0, o_src=0, o_blank=0, o_state=0, tick counter=0, hold counter=0, blink phase=0, lap register=0.
- Tick generation:
  - Free-running counter counts 0..CLK_DIV-1.
  - tick is asserted for one clk on the wrap cycle.
- Hold counter:
  - Width is $clog2(HOLD_MS+1).
  - Loads HOLD_MS on entry to PEEK or LAP, and on a re-trigger while in them.
  - Decrements on tick; saturates at 0.
- Transitions (all evaluated every clk):
  - A change in i_mode has priority over i_sw_event and i_lap in the same cycle.
  - WATCH: i_mode=1 -> SW. Else i_sw_event -> PEEK (load hold).
  - SW: i_mode=0 -> WATCH. Else i_lap -> LAP (latch i_sw_time into lap register, load hold).
  - PEEK: i_mode=1 -> SW. Else i_sw_event -> stay in PEEK and reload hold. Else tick while hold==1 -> WATCH.
  - LAP: i_mode=0 -> WATCH (lap discarded). Else i_lap -> re-latch i_sw_time and reload hold. Else tick while hold==1 -> SW.
  - i_lap in WATCH or PEEK is ignored. i_sw_event in SW or LAP is ignored.
- Outputs (all registered; 1-clk latency from inputs and state):
  - o_time: i_watch_time in WATCH, i_sw_time in SW and PEEK, lap register in LAP. Live sources are re-sampled every clk.
  - o_page: i_page in WATCH, SW and LAP. Forced to 0 in PEEK.
  - o_src: 0 in WATCH, 1 otherwise.
- Blink:
  - Active only when state==WATCH and i_edit_en=1.
  - Phase toggles every BLINK_MS ticks.
  - Phase and blink counter clear to 0 (visible) whenever blink is inactive or i_edit_field changes value.
- Blank mask:
  - Field mask for page 0: sec -> 4'b1100; any other field -> 0.
  - Field mask for page 1: min -> 4'b0011, hour -> 4'b1100; sec and reserved -> 0.
  - o_blank = field mask when phase=1, else 0.
  - o_blank is always 0 outside WATCH.
- Reset mid-PEEK or mid-LAP: next cycle is WATCH with all reset values, and the lap register is cleared.
- Simultaneous tick with hold==1 and a re-trigger: the re-trigger wins; hold reloads and the state is held.

Test Plan:
Bench params for all scenarios: CLK_DIV=4, HOLD_MS=3, BLINK_MS=2.
1. Reset:
   - Stimulus: assert reset with i_watch_time=24'h0A_BCDE.
   - Required: all outputs 0 during reset. The first clk after deassert gives o_time=24'h0A_BCDE, o_src=0, o_state=0.
2. Mode switch:
   - Stimulus: i_mode 0->1 with i_sw_time=24'h000123, i_page=1.
   - Required: o_state=1, o_src=1, o_time=24'h000123, o_page=1 one clk later. i_mode->0 returns to WATCH the next clk.
3. Peek:
   - Stimulus: in WATCH with i_page=1, pulse i_sw_event.
   - Required: o_state=2, o_page=0, o_time tracks i_sw_time. Returns to WATCH after exactly the 3rd tick following entry.
   - A second i_sw_event after 2 ticks extends PEEK by 3 further ticks.
4. Lap freeze:
   - Stimulus: in SW, pulse i_lap while i_sw_time=24'h0010_32, then keep incrementing i_sw_time.
   - Required: o_time stays 24'h0010_32 for 3 ticks, then o_state=1 and o_time resumes tracking i_sw_time.
   - i_mode->0 during LAP goes straight to WATCH.
5. Blink:
   - Stimulus: WATCH, i_page=1, i_edit_en=1, i_edit_field=2.
   - Required: o_blank alternates 0 / 4'b1100 every 2 ticks. Changing the field to 1 immediately gives 0, then 4'b0011 after 2 ticks. i_edit_field=0 on page 1 gives 0 constantly.
6. Priority:
   - Stimulus: in WATCH, i_mode rises in the same cycle as an i_sw_event pulse.
   - Required: the state goes to SW, not PEEK.
   - Reset asserted mid-LAP -> WATCH with o_time equal to the watch time one clk after release.
